// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one synchronous single-port RAM between the CPU MEM
// stage and a loader/debug port, with round-robin priority and a one-cycle load response.
module ram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,

  output logic          ram_read_enable,
  output logic          ram_write_enable,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic SIDE_CPU = 1'b0;
  localparam logic SIDE_DBG = 1'b1;

  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;
  logic          prio_reg, prio_next;
  logic [DW-1:0] cpu_rdata_reg, dbg_rdata_reg;
  logic          owner_we;
  logic          cpu_elig, dbg_elig;

  // Requesters hold we stable through their grant, so the live input is the owner's we.
  assign owner_we = (owner_reg == SIDE_DBG) ? dbg_we : cpu_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      owner_reg     <= SIDE_CPU;
      prio_reg      <= SIDE_CPU;
      cpu_rdata_reg <= '0;
      dbg_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      prio_reg  <= prio_next;
      if (cpu_rvalid) cpu_rdata_reg <= ram_rdata;
      if (dbg_rvalid) dbg_rdata_reg <= ram_rdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    prio_next  = prio_reg;
    // The owner's request is already being served in its ACCESS cycle.
    cpu_elig   = cpu_req & ~((state_reg == ACCESS) && (owner_reg == SIDE_CPU));
    dbg_elig   = dbg_req & ~((state_reg == ACCESS) && (owner_reg == SIDE_DBG));
    if ((state_reg == ACCESS) && !owner_we) begin
      state_next = RESP;
    end else if (cpu_elig || dbg_elig) begin
      state_next = ACCESS;
      if (cpu_elig && dbg_elig) owner_next = prio_reg;
      else                      owner_next = dbg_elig;
      prio_next = ~owner_next;
    end else begin
      state_next = IDLE;
    end
  end

  always_comb begin
    cpu_gnt          = 1'b0;
    dbg_gnt          = 1'b0;
    cpu_rvalid       = 1'b0;
    dbg_rvalid       = 1'b0;
    ram_read_enable  = 1'b0;
    ram_write_enable = 1'b0;
    ram_addr         = '0;
    ram_data         = '0;
    if (state_reg == ACCESS) begin
      cpu_gnt          = (owner_reg == SIDE_CPU);
      dbg_gnt          = (owner_reg == SIDE_DBG);
      ram_write_enable = owner_we;
      ram_read_enable  = ~owner_we;
      ram_addr         = (owner_reg == SIDE_DBG) ? dbg_addr  : cpu_addr;
      ram_data         = (owner_reg == SIDE_DBG) ? dbg_wdata : cpu_wdata;
    end
    if (state_reg == RESP) begin
      cpu_rvalid = (owner_reg == SIDE_CPU);
      dbg_rvalid = (owner_reg == SIDE_DBG);
    end
  end

  // RAM data arrives in the RESP cycle itself, so it bypasses the hold register then.
  assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_reg;
  assign dbg_rdata = dbg_rvalid ? ram_rdata : dbg_rdata_reg;

  assign cpu_stall = reset &
                     ((cpu_req & ~(cpu_gnt & cpu_we) & ~cpu_rvalid) |
                      (cpu_gnt & ~cpu_we));

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: a transaction-schedule reference model
// predicts every output each cycle, plus directed scenarios for the key cases.
module tb_ram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          ram_read_enable, ram_write_enable;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_rdata = '0;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM environment, 16 words aliased on the low address bits.
  logic [DW-1:0] env_mem [16];
  always @(posedge clk) begin
    if (ram_write_enable) env_mem[ram_addr[3:0]] <= ram_data;
    if (ram_read_enable)  ram_rdata <= env_mem[ram_addr[3:0]];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: which side accesses the RAM this cycle, which side gets its response.
  int            m_acc = -1;
  int            m_resp = -1;
  int            m_turn = 0;
  logic [DW-1:0] m_resp_data = '0;
  logic [DW-1:0] m_last [2];
  logic [DW-1:0] m_mem [16];

  bit            s_cgnt, s_dgnt, s_we, s_re, s_stall, s_drv;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data, s_drdata;
  int            g_side [$];
  int            g_cyc [$];
  int            n_dgnt = 0;
  int            n_strobe = 0;

  function automatic logic side_we(input int s);
    return (s == 0) ? cpu_we : dbg_we;
  endfunction
  function automatic logic [AW-1:0] side_addr(input int s);
    return (s == 0) ? cpu_addr : dbg_addr;
  endfunction
  function automatic logic [DW-1:0] side_wdata(input int s);
    return (s == 0) ? cpu_wdata : dbg_wdata;
  endfunction

  task automatic model_reset();
    m_acc = -1;
    m_resp = -1;
    m_turn = 0;
    m_last[0] = '0;
    m_last[1] = '0;
  endtask

  task automatic check_outputs();
    logic ewe;
    logic egc, egd, ecrv, edrv;
    ewe  = (m_acc >= 0) ? side_we(m_acc) : 1'b0;
    egc  = (m_acc == 0);
    egd  = (m_acc == 1);
    ecrv = (m_resp == 0);
    edrv = (m_resp == 1);
    check("cpu_gnt", cpu_gnt, egc);
    check("dbg_gnt", dbg_gnt, egd);
    check("ram_we", ram_write_enable, (m_acc >= 0) && ewe);
    check("ram_re", ram_read_enable, (m_acc >= 0) && !ewe);
    check("ram_addr", ram_addr, (m_acc >= 0) ? side_addr(m_acc) : '0);
    check("ram_data", ram_data, (m_acc >= 0) ? side_wdata(m_acc) : '0);
    check("cpu_rvalid", cpu_rvalid, ecrv);
    check("dbg_rvalid", dbg_rvalid, edrv);
    check("cpu_rdata", cpu_rdata, ecrv ? m_resp_data : m_last[0]);
    check("dbg_rdata", dbg_rdata, edrv ? m_resp_data : m_last[1]);
    check("cpu_stall", cpu_stall,
          (cpu_req & ~(egc & cpu_we) & ~ecrv) | (egc & ~cpu_we));
  endtask

  task automatic model_step();
    int            nresp;
    int            win;
    bit            ce, de;
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    nresp = -1;
    win = -1;
    rd = '0;
    if (m_acc >= 0) begin
      a = side_addr(m_acc);
      if (side_we(m_acc)) m_mem[a[3:0]] = side_wdata(m_acc);
      else begin
        nresp = m_acc;
        rd = m_mem[a[3:0]];
      end
    end
    if (m_resp >= 0) m_last[m_resp] = m_resp_data;
    // Every cycle except a read's ACCESS cycle picks the next owner.
    if (nresp < 0) begin
      ce = cpu_req && (m_acc != 0);
      de = dbg_req && (m_acc != 1);
      if (ce && de) win = m_turn;
      else if (ce)  win = 0;
      else if (de)  win = 1;
      if (win >= 0) m_turn = 1 - win;
    end
    m_acc = win;
    m_resp = nresp;
    if (nresp >= 0) m_resp_data = rd;
  endtask

  task automatic tick();
    @(negedge clk);
    s_cgnt = cpu_gnt; s_dgnt = dbg_gnt; s_we = ram_write_enable; s_re = ram_read_enable;
    s_stall = cpu_stall; s_drv = dbg_rvalid; s_addr = ram_addr; s_data = ram_data;
    s_drdata = dbg_rdata;
    if (cpu_gnt) begin g_side.push_back(0); g_cyc.push_back(cyc); end
    if (dbg_gnt) begin g_side.push_back(1); g_cyc.push_back(cyc); n_dgnt++; end
    if (ram_read_enable || ram_write_enable) n_strobe++;
    check_outputs();
    model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_cpu_gnt", cpu_gnt, 1'b0);
    check("rst_dbg_gnt", dbg_gnt, 1'b0);
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    check("rst_cpu_stall", cpu_stall, 1'b0);
    check("rst_strobes", {ram_read_enable, ram_write_enable}, 2'b00);
    check("rst_ram_addr", ram_addr, '0);
    check("rst_ram_data", ram_data, '0);
    check("rst_cpu_rdata", cpu_rdata, '0);
    check("rst_dbg_rdata", dbg_rdata, '0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    $display("reset cycle=%0d", cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit c_hold, d_hold;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    #1;
    cpu_req = 1'b1;   // stall must stay low while reset is held
    do_reset();
    cpu_req = 1'b0;

    // Fill the RAM through the CPU port so both RAM copies are known.
    for (int i = 0; i < 16; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(i); cpu_wdata = $urandom;
      tick();
      tick();
    end
    cpu_req = 1'b0;
    tick();

    // Lone CPU store.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    tick();
    check("store_stall_req", s_stall, 1'b1);
    tick();
    check("store_gnt", s_cgnt, 1'b1);
    check("store_we", s_we, 1'b1);
    check("store_addr", s_addr, 32'h10);
    check("store_data", s_data, 32'hDEADBEEF);
    check("store_stall_gnt", s_stall, 1'b0);
    cpu_req = 1'b0;
    tick();
    $display("txn store cpu addr=0x10 data=0xdeadbeef");

    // Lone debug load of the word just stored.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    tick();
    tick();
    check("load_gnt", s_dgnt, 1'b1);
    check("load_re", s_re, 1'b1);
    dbg_req = 1'b0;
    tick();
    check("load_rvalid", s_drv, 1'b1);
    check("load_rdata", s_drdata, 32'hDEADBEEF);
    tick();
    $display("txn load dbg addr=0x10 rdata=0x%0h", s_drdata);

    // Simultaneous stores right after reset: CPU then DBG back to back.
    do_reset();
    g_side.delete(); g_cyc.delete();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4; cpu_wdata = 32'h1111_2222;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h5; dbg_wdata = 32'h3333_4444;
    tick();
    tick();
    cpu_req = 1'b0;
    tick();
    dbg_req = 1'b0;
    tick();
    check("simul_count", g_side.size(), 2);
    check("simul_first", g_side[0], 0);
    check("simul_second", g_side[1], 1);
    check("simul_gap", g_cyc[1] - g_cyc[0], 1);
    $display("txn simultaneous stores grants=%0d", g_side.size());

    // Fairness: both sides keep requesting loads.
    do_reset();
    g_side.delete(); g_cyc.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h5;
    for (int i = 0; i < 12; i++) tick();
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
    tick();
    check("fair_count", g_side.size(), 6);
    for (int i = 0; i < 6; i++) check("fair_order", g_side[i], i % 2);
    for (int i = 1; i < 6; i++) check("fair_spacing", g_cyc[i] - g_cyc[i-1], 2);
    $display("txn fairness grants=%0d", g_side.size());

    // Reset during a CPU load's ACCESS cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7;
    tick();
    check("midrst_gnt_before", cpu_gnt, 1'b1);
    do_reset();
    g_side.delete(); g_cyc.delete();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8;
    tick();
    check("midrst_no_rvalid", cpu_rvalid, 1'b0);
    tick();
    check("midrst_next_cpu", s_cgnt, 1'b1);
    cpu_req = 1'b0;
    tick();
    tick();
    dbg_req = 1'b0;
    tick();
    tick();
    $display("txn reset mid-access grants=%0d", g_side.size());

    // Debug request withdrawn while the CPU owns a read access.
    n_dgnt = 0; n_strobe = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3;
    tick();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h9;
    tick();
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
    tick();
    check("withdraw_no_gnt", n_dgnt, 0);
    check("withdraw_strobes", n_strobe, 1);
    $display("txn withdrawal dbg_gnts=%0d strobes=%0d", n_dgnt, n_strobe);

    // Random traffic; requests are held until granted.
    c_hold = 1'b0; d_hold = 1'b0; s_cgnt = 1'b0; s_dgnt = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (c_hold && s_cgnt) c_hold = 1'b0;
      if (!c_hold && ($urandom_range(0, 1) == 1)) begin
        c_hold = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (d_hold && s_dgnt) d_hold = 1'b0;
      if (!d_hold && ($urandom_range(0, 1) == 1)) begin
        d_hold = 1'b1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = $urandom; dbg_wdata = $urandom;
      end
      cpu_req = c_hold;
      dbg_req = d_hold;
      if ($urandom_range(0, 399) == 0) do_reset();
      tick();
    end
    $display("txn random cycles=%0d", cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset: low clears all state immediately, independent of clk.
REQ-005 SHALL have ports cpu_req/cpu_we  input  1/1  MEM-stage access request / 1=store, 0=load.
REQ-006 SHALL have ports cpu_addr/cpu_wdata  input  AW/DW  MEM-stage address / store data.
REQ-007 SHALL have ports cpu_gnt/cpu_rvalid/cpu_stall  output  1/1/1  access issued / load data valid / hold pipeline.
REQ-008 SHALL have port cpu_rdata  output  DW  load data, meaningful only while cpu_rvalid=1.
REQ-009 SHALL have ports dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata with the same directions, widths and meanings as the cpu_* set, for the loader/debug port.
REQ-010 SHALL have ports ram_read_enable/ram_write_enable  output  1/1  RAM strobes.
REQ-011 SHALL have ports ram_addr/ram_data  output  AW/DW  RAM address / write data.
REQ-012 SHALL have port ram_rdata  input  DW  synchronous RAM read data, valid one cycle after ram_read_enable.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-014 SHALL treat IDLE, RESP, and ACCESS-with-write as decision cycles: if any eligible request is present, latch the winner into owner and go to ACCESS next cycle; otherwise go to IDLE.
REQ-015 SHALL mask the current owner's req during its own ACCESS cycle, so that one request is never granted twice.
REQ-016 SHALL arbitrate round-robin using a 1-bit prio register: prio=CPU at reset; when both requesters are eligible, the prio side wins; a lone requester wins regardless of prio.
REQ-017 SHALL set prio to the non-owner side on every grant.
REQ-018 SHALL, in ACCESS, drive for exactly one cycle: owner's gnt=1, ram_addr=owner addr, ram_data=owner wdata, ram_write_enable=owner we, ram_read_enable=~owner we.
REQ-019 SHALL go from ACCESS-with-read to RESP.
REQ-020 SHALL, in RESP, assert owner's rvalid=1 and present ram_rdata on owner's rdata for exactly one cycle.
REQ-021 SHALL hold both strobes, both gnt and both rvalid at 0 in every cycle not covered by REQ-018 and REQ-020.
REQ-022 SHALL give the following latency from req first seen in IDLE: gnt at +1, rvalid at +2; a request that loses arbitration waits at most one extra transaction.
REQ-023 SHALL define cpu_stall = cpu_req & ~(cpu_gnt & cpu_we), OR a cpu load granted whose cpu_rvalid has not yet occurred; cpu_stall deasserts in the rvalid cycle.
REQ-024 SHALL require a requester to hold req/we/addr/wdata stable until its gnt; a req dropped before its gnt causes no RAM access.
REQ-025 SHALL pass address and data through unmodified, with no width truncation or alignment check.
REQ-026 SHALL register rdata outputs, and SHALL hold each rdata output at its last value when rvalid=0.

Reset
REQ-027 SHALL, while reset=0, force state=IDLE, prio=CPU, owner=CPU, and every output to 0, including the rdata buses.
REQ-028 SHALL, on reset asserted mid-ACCESS or mid-RESP, abandon the transaction: no rvalid is ever produced for it.
REQ-029 SHALL make its first decision in the first rising edge after reset returns high.

Verification
REQ-030 SHALL cover a lone CPU store: cpu_req=1, we=1, addr=0x10, wdata=0xDEADBEEF -> next cycle cpu_gnt=1, ram_write_enable=1, ram_addr=0x10, ram_data=0xDEADBEEF; cpu_stall=1 only in the req cycle.
REQ-031 SHALL cover a lone debug load: dbg load addr=0x10 with the RAM returning 0xDEADBEEF -> dbg_gnt at +1, ram_read_enable=1 at +1, dbg_rvalid=1 with dbg_rdata=0xDEADBEEF at +2.
REQ-032 SHALL cover simultaneous requests after reset: cpu_req and dbg_req both high, both stores -> CPU granted first, DBG granted the following cycle, zero idle cycles between the two ACCESS cycles.
REQ-033 SHALL cover fairness: both requesters continuously requesting loads for 6 transactions -> grants alternate CPU, DBG, CPU, DBG, CPU, DBG, one transaction per 2 cycles.
REQ-034 SHALL cover reset mid-operation: reset driven low during a CPU load's ACCESS cycle -> all outputs 0 immediately, no cpu_rvalid after release, and the next grant goes to CPU.
REQ-035 SHALL cover early withdrawal: dbg_req high for one cycle while the CPU owns ACCESS-read, then dropped -> dbg_gnt never asserts and no extra RAM strobe occurs.
